// File: rtl/load_unit.sv
// load_unit: single-outstanding load engine between a pipeline and a simple
// read bus. Checks the address (alignment and memory map), issues a
// word-aligned bus read, waits for the response with a timeout, then returns
// the byte/half/word lane aligned to bit 0 and sign- or zero-extended.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   Req          interrupt/flush: blocks new loads, aborts an outstanding one
//   ld_valid     load request present this cycle
//   addr         byte address of the load
//   LSOp         access size: 01 byte, 10 half, 11 word, 00 none
//   sign_ext     1 = sign-extend byte/half, 0 = zero-extend
//   ld_ready     unit idle; a request is accepted this cycle
//   mem_rd_en    bus read strobe, held until response, abort or timeout
//   mem_addr     word-aligned bus address of the outstanding load
//   mem_rdata    bus read data, valid with mem_rvalid
//   mem_rvalid   bus read response
//   stall        hold the upstream pipeline
//   rd_data      aligned, extended load result (held between loads)
//   rd_valid     one-cycle pulse, rd_data valid
//   MEM_EXC_AdEL one-cycle pulse, address error on load
//   bus_err      one-cycle pulse, response timeout
module load_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        ld_valid,
    input  logic [31:0] addr,
    input  logic [1:0]  LSOp,
    input  logic        sign_ext,
    output logic        ld_ready,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        MEM_EXC_AdEL,
    output logic        bus_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] OP_BYTE = 2'b01;
    localparam logic [1:0] OP_HALF = 2'b10;
    localparam logic [1:0] OP_WORD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [29:0]     word_addr;
    logic [1:0]      cap_off;
    logic [1:0]      cap_size;
    logic            cap_sign;

    logic            qualified;
    logic            in_dm;
    logic            in_tc0;
    logic            in_tc1;
    logic            in_stall;
    logic            adel;
    logic            accept;
    logic            reject;
    logic            load_data;
    logic            timeout;
    logic [31:0]     ext_data;

    // Address-error decode on the incoming request.
    always_comb begin
        in_dm    = (addr <= 32'h0000_2fff);
        in_tc0   = (addr >= 32'h0000_7f00) && (addr <= 32'h0000_7f0b);
        in_tc1   = (addr >= 32'h0000_7f10) && (addr <= 32'h0000_7f1b);
        in_stall = (addr >= 32'h0000_7f20) && (addr <= 32'h0000_7f23);
        adel = 1'b0;
        if ((LSOp == OP_WORD) && (addr[1:0] != 2'b00))
            adel = 1'b1;
        if ((LSOp == OP_HALF) && addr[0])
            adel = 1'b1;
        if (!(in_dm || in_tc0 || in_tc1 || in_stall))
            adel = 1'b1;
        // Timer registers only support full-word access.
        if (((LSOp == OP_BYTE) || (LSOp == OP_HALF)) && (in_tc0 || in_tc1))
            adel = 1'b1;
    end

    assign qualified = ld_valid && (LSOp != 2'b00) && !Req;

    // Lane extraction and extension of the bus response.
    always_comb begin
        ext_data = mem_rdata;
        case (cap_size)
            OP_BYTE: begin
                logic [7:0] b;
                case (cap_off)
                    2'b00:   b = mem_rdata[7:0];
                    2'b01:   b = mem_rdata[15:8];
                    2'b10:   b = mem_rdata[23:16];
                    default: b = mem_rdata[31:24];
                endcase
                ext_data = {{24{cap_sign & b[7]}}, b};
            end
            OP_HALF: begin
                logic [15:0] h;
                h = cap_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
                ext_data = {{16{cap_sign & h[15]}}, h};
            end
            default: ext_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        load_data  = 1'b0;
        timeout    = 1'b0;
        ld_ready   = 1'b0;
        mem_rd_en  = 1'b0;
        rd_valid   = 1'b0;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                ld_ready = 1'b1;
                if (qualified) begin
                    if (adel) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        stall      = 1'b1;
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                mem_rd_en = 1'b1;
                stall     = 1'b1;
                // Abort beats a response; a response beats the timeout.
                if (Req) begin
                    next_state = S_IDLE;
                end else if (mem_rvalid) begin
                    load_data  = 1'b1;
                    next_state = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_DONE: begin
                rd_valid   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            word_addr    <= '0;
            cap_off      <= '0;
            cap_size     <= '0;
            cap_sign     <= 1'b0;
            rd_data      <= '0;
            MEM_EXC_AdEL <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            MEM_EXC_AdEL <= reject;
            bus_err      <= timeout;
            if (accept) begin
                cnt       <= '0;
                word_addr <= addr[31:2];
                cap_off   <= addr[1:0];
                cap_size  <= LSOp;
                cap_sign  <= sign_ext;
            end else if ((state == S_WAIT) && !mem_rvalid) begin
                cnt <= cnt + 1'b1;
            end
            if (load_data)
                rd_data <= ext_data;
        end
    end

    assign mem_addr = {word_addr, 2'b00};

endmodule
